// File: rtl/tcdm_port_arbiter.sv
// Round-robin arbiter sharing one narrow TCDM subsystem port among NumReq requesters.
// Winner IDs are queued in order so each response is routed back to its requester.
module tcdm_port_arbiter #(
    parameter int unsigned NumReq          = 4,
    parameter int unsigned NarrowDataWidth = 64,
    parameter int unsigned TCDMAddrWidth   = 12,
    parameter int unsigned MaxOutstanding  = 4
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [NumReq-1:0]                             req_write_i,
    input  logic [NumReq-1:0][TCDMAddrWidth-1:0]          req_addr_i,
    input  logic [NumReq-1:0][3:0]                        req_amo_i,
    input  logic [NumReq-1:0][NarrowDataWidth-1:0]        req_data_i,
    input  logic [NumReq-1:0][4:0]                        req_user_core_id_i,
    input  logic [NumReq-1:0]                             req_user_is_core_i,
    input  logic [NumReq-1:0][NarrowDataWidth/8-1:0]      req_strb_i,
    input  logic [NumReq-1:0]                             req_q_valid_i,
    output logic [NumReq-1:0]                             req_q_ready_o,
    output logic [NumReq-1:0]                             rsp_p_valid_o,
    output logic [NumReq-1:0][NarrowDataWidth-1:0]        rsp_data_o,
    output logic                                          tcdm_req_write_o,
    output logic [TCDMAddrWidth-1:0]                      tcdm_req_addr_o,
    output logic [3:0]                                    tcdm_req_amo_o,
    output logic [NarrowDataWidth-1:0]                    tcdm_req_data_o,
    output logic [4:0]                                    tcdm_req_user_core_id_o,
    output logic                                          tcdm_req_user_is_core_o,
    output logic [NarrowDataWidth/8-1:0]                  tcdm_req_strb_o,
    output logic                                          tcdm_req_q_valid_o,
    input  logic                                          tcdm_rsp_q_ready_i,
    input  logic                                          tcdm_rsp_p_valid_i,
    input  logic [NarrowDataWidth-1:0]                    tcdm_rsp_data_i,
    output logic                                          err_o
);
    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef enum logic {ARB, HOLD} state_e;

    state_e          state;
    logic [IdxW-1:0] rr_ptr, hold_idx, arb_idx, win_idx, head_idx, cand;
    logic            arb_found;
    logic [IdxW-1:0] id_fifo [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic [CntW-1:0] count;
    logic            fifo_full, fifo_empty, offer, handshake, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign fifo_full  = (count == CntW'(MaxOutstanding));
    assign fifo_empty = (count == '0);

    // First valid requester at or after rr_ptr, wrapping around
    always_comb begin
        arb_idx   = rr_ptr;
        arb_found = 1'b0;
        cand      = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            cand = IdxW'((int'(rr_ptr) + i) % int'(NumReq));
            if (!arb_found && req_q_valid_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    assign win_idx   = (state == HOLD) ? hold_idx : arb_idx;
    assign offer     = ((state == HOLD) ? req_q_valid_i[hold_idx] : (|req_q_valid_i)) & ~fifo_full;
    assign handshake = offer & tcdm_rsp_q_ready_i;
    assign pop       = tcdm_rsp_p_valid_i & ~fifo_empty;
    assign head_idx  = id_fifo[rd_ptr];

    assign tcdm_req_q_valid_o      = offer;
    assign tcdm_req_write_o        = req_write_i[win_idx];
    assign tcdm_req_addr_o         = req_addr_i[win_idx];
    assign tcdm_req_amo_o          = req_amo_i[win_idx];
    assign tcdm_req_data_o         = req_data_i[win_idx];
    assign tcdm_req_user_core_id_o = req_user_core_id_i[win_idx];
    assign tcdm_req_user_is_core_o = req_user_is_core_i[win_idx];
    assign tcdm_req_strb_o         = req_strb_i[win_idx];

    always_comb begin
        req_q_ready_o = '0;
        rsp_p_valid_o = '0;
        if (offer) req_q_ready_o[win_idx] = tcdm_rsp_q_ready_i;
        if (pop)   rsp_p_valid_o[head_idx] = 1'b1;
    end

    for (genvar g = 0; g < NumReq; g++) begin : g_rsp_data
        assign rsp_data_o[g] = tcdm_rsp_data_i;
    end

    // ID storage needs no reset; occupancy is tracked by count
    always_ff @(posedge clk_i) begin
        if (handshake) id_fifo[wr_ptr] <= win_idx;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ARB;
            hold_idx <= '0;
            rr_ptr   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err_o    <= 1'b0;
        end else begin
            if (state == ARB) begin
                if (offer && !tcdm_rsp_q_ready_i) begin
                    state    <= HOLD;
                    hold_idx <= arb_idx;
                end
            end else if (handshake) begin
                state <= ARB;
            end
            if (handshake) begin
                wr_ptr <= ptr_inc(wr_ptr);
                rr_ptr <= (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + IdxW'(1);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (handshake && !pop)      count <= count + CntW'(1);
            else if (!handshake && pop) count <= count - CntW'(1);
            if (tcdm_rsp_p_valid_i && fifo_empty) err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tcdm_port_arbiter.sv
// Scoreboard bench for tcdm_port_arbiter: directed requests feed expected grant/response
// queues that a negedge monitor drains; a small TCDM memory model answers in order.
module tb_tcdm_port_arbiter;
    localparam int NR = 4;
    localparam int DW = 64;
    localparam int AW = 12;

    typedef struct { int idx; logic write; logic [AW-1:0] addr; logic [DW-1:0] data; } stim_t;
    typedef struct { int idx; logic [AW-1:0] addr; } grant_t;
    typedef struct { int idx; logic [DW-1:0] data; } rsp_t;
    typedef struct { int due; logic [DW-1:0] data; } pend_t;

    logic clk, rst_n;
    logic [NR-1:0]             req_write_i, req_user_is_core_i, req_q_valid_i, req_q_ready_o, rsp_p_valid_o;
    logic [NR-1:0][AW-1:0]     req_addr_i;
    logic [NR-1:0][3:0]        req_amo_i;
    logic [NR-1:0][DW-1:0]     req_data_i, rsp_data_o;
    logic [NR-1:0][4:0]        req_user_core_id_i;
    logic [NR-1:0][DW/8-1:0]   req_strb_i;
    logic                      tcdm_req_write_o, tcdm_req_user_is_core_o, tcdm_req_q_valid_o;
    logic [AW-1:0]             tcdm_req_addr_o;
    logic [3:0]                tcdm_req_amo_o;
    logic [DW-1:0]             tcdm_req_data_o, tcdm_rsp_data_i;
    logic [4:0]                tcdm_req_user_core_id_o;
    logic [DW/8-1:0]           tcdm_req_strb_o;
    logic                      tcdm_rsp_q_ready_i, tcdm_rsp_p_valid_i, err_o;

    stim_t  stim_q[$];
    grant_t exp_grant[$];
    rsp_t   exp_rsp[$];
    pend_t  pend_rsp[$];
    int     lat_q[$];
    logic [DW-1:0] mem [512];

    int n_cmp = 0, n_err = 0;
    int cyc = 0, last_due = 0, grant_cnt = 0, last_grant_cyc = 0;
    int rsp_budget = -1;
    logic inject = 1'b0;
    logic [NR-1:0] acc = '0, busy = '0;

    int g, lat, found, t, base, t_start;
    grant_t ge;
    rsp_t re;
    pend_t pe;
    stim_t s;

    tcdm_port_arbiter #(.NumReq(NR), .NarrowDataWidth(DW), .TCDMAddrWidth(AW), .MaxOutstanding(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_write_i(req_write_i), .req_addr_i(req_addr_i), .req_amo_i(req_amo_i),
        .req_data_i(req_data_i), .req_user_core_id_i(req_user_core_id_i),
        .req_user_is_core_i(req_user_is_core_i), .req_strb_i(req_strb_i),
        .req_q_valid_i(req_q_valid_i), .req_q_ready_o(req_q_ready_o),
        .rsp_p_valid_o(rsp_p_valid_o), .rsp_data_o(rsp_data_o),
        .tcdm_req_write_o(tcdm_req_write_o), .tcdm_req_addr_o(tcdm_req_addr_o),
        .tcdm_req_amo_o(tcdm_req_amo_o), .tcdm_req_data_o(tcdm_req_data_o),
        .tcdm_req_user_core_id_o(tcdm_req_user_core_id_o),
        .tcdm_req_user_is_core_o(tcdm_req_user_is_core_o), .tcdm_req_strb_o(tcdm_req_strb_o),
        .tcdm_req_q_valid_o(tcdm_req_q_valid_o), .tcdm_rsp_q_ready_i(tcdm_rsp_q_ready_i),
        .tcdm_rsp_p_valid_i(tcdm_rsp_p_valid_i), .tcdm_rsp_data_i(tcdm_rsp_data_i),
        .err_o(err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic reportFail(input string name);
        n_cmp++;
        n_err++;
        $display("[TB] FAIL %s: timed out or unexpected event", name);
    endtask

    // Queue one request; stimulus order must equal the expected grant order
    task automatic applyStimulus(input int idx, input logic write, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input logic [DW-1:0] rdata, input int l);
        stim_q.push_back('{idx, write, addr, data});
        exp_grant.push_back('{idx, addr});
        exp_rsp.push_back('{idx, rdata});
        lat_q.push_back(l);
    endtask

    task automatic waitIdle(input string name);
        int k = 0;
        while ((stim_q.size() != 0 || busy != '0 || exp_grant.size() != 0 ||
                exp_rsp.size() != 0 || pend_rsp.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) reportFail(name);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Requester drivers: hold each request until its handshake, then load the next
    initial begin
        req_write_i = '0; req_addr_i = '0; req_amo_i = '0; req_data_i = '0;
        req_user_core_id_i = '0; req_user_is_core_i = '0; req_strb_i = '0; req_q_valid_i = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) begin
                    req_q_valid_i[i] = 1'b0;
                    busy[i] = 1'b0;
                    acc[i] = 1'b0;
                end
                if (!busy[i]) begin
                    found = -1;
                    for (int k = 0; k < stim_q.size(); k++)
                        if (found < 0 && stim_q[k].idx == i) found = k;
                    if (found >= 0) begin
                        s = stim_q[found];
                        stim_q.delete(found);
                        req_write_i[i] = s.write;
                        req_addr_i[i] = s.addr;
                        req_data_i[i] = s.data;
                        req_strb_i[i] = '1;
                        req_amo_i[i] = '0;
                        req_user_core_id_i[i] = 5'(i);
                        req_user_is_core_i[i] = 1'b1;
                        req_q_valid_i[i] = 1'b1;
                        busy[i] = 1'b1;
                    end
                end
            end
        end
    end

    // TCDM responder: in-order responses once their due cycle is reached
    initial begin
        tcdm_rsp_p_valid_i = 1'b0;
        tcdm_rsp_data_i = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            tcdm_rsp_p_valid_i = 1'b0;
            tcdm_rsp_data_i = '0;
            if (inject) begin
                tcdm_rsp_p_valid_i = 1'b1;
                tcdm_rsp_data_i = 64'hDEAD_BEEF;
            end else if (pend_rsp.size() != 0 && rsp_budget != 0 && pend_rsp[0].due <= cyc) begin
                pe = pend_rsp.pop_front();
                tcdm_rsp_p_valid_i = 1'b1;
                tcdm_rsp_data_i = pe.data;
                if (rsp_budget > 0) rsp_budget--;
            end
        end
    end

    // Monitor: compares grants and responses against the scoreboard queues
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (tcdm_req_q_valid_o && tcdm_rsp_q_ready_i) begin
                    g = -1;
                    for (int i = 0; i < NR; i++) if (req_q_ready_o[i]) g = i;
                    if (exp_grant.size() == 0) reportFail("unexpected_grant");
                    else begin
                        ge = exp_grant.pop_front();
                        checkOutput("grant_idx", 64'(g), 64'(ge.idx));
                        checkOutput("grant_addr", 64'(tcdm_req_addr_o), 64'(ge.addr));
                        checkOutput("grant_side",
                                    64'({tcdm_req_amo_o, tcdm_req_user_core_id_o, tcdm_req_user_is_core_o, tcdm_req_strb_o}),
                                    64'({4'h0, 5'(ge.idx), 1'b1, 8'hFF}));
                    end
                    if (g >= 0) acc[g] = 1'b1;
                    pe.data = tcdm_req_write_o ? 64'h0 : mem[tcdm_req_addr_o[11:3]];
                    if (tcdm_req_write_o) mem[tcdm_req_addr_o[11:3]] = tcdm_req_data_o;
                    lat = (lat_q.size() != 0) ? lat_q.pop_front() : 1;
                    pe.due = cyc + lat;
                    if (pe.due <= last_due) pe.due = last_due + 1;
                    last_due = pe.due;
                    pend_rsp.push_back(pe);
                    grant_cnt++;
                    last_grant_cyc = cyc;
                end
                if (rsp_p_valid_o != '0) begin
                    if (exp_rsp.size() == 0) reportFail("unexpected_rsp");
                    else begin
                        re = exp_rsp.pop_front();
                        checkOutput("rsp_onehot", 64'(rsp_p_valid_o), 64'(1) << re.idx);
                        checkOutput("rsp_data", rsp_data_o[re.idx], re.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        rst_n = 1'b0;
        tcdm_rsp_q_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_q_valid", 64'(tcdm_req_q_valid_o), 64'(0));
        checkOutput("reset_q_ready", 64'(req_q_ready_o), 64'(0));
        checkOutput("reset_p_valid", 64'(rsp_p_valid_o), 64'(0));
        checkOutput("reset_err", 64'(err_o), 64'(0));
        rst_n = 1'b1;

        $display("[TB] write then read back through requester 2");
        applyStimulus(2, 1'b1, 12'h040, 64'hA5, 64'h0, 1);
        applyStimulus(2, 1'b0, 12'h040, 64'h0, 64'hA5, 1);
        waitIdle("t1_idle");

        $display("[TB] all requesters valid, round-robin order");
        doReset();
        t_start = cyc;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++)
                applyStimulus(i, 1'b1, 12'(256 * (i + 1) + 8 * r), 64'(16 * (i + 1) + r + 1), 64'h0, 1);
        waitIdle("t2_idle");
        checkOutput("t2_one_per_cycle", 64'(last_grant_cyc - t_start), 64'(8));

        $display("[TB] hold under back-pressure");
        @(posedge clk);
        #1;
        tcdm_rsp_q_ready_i = 1'b0;
        @(negedge clk);
        applyStimulus(1, 1'b0, 12'h200, 64'h0, 64'h21, 1);
        @(negedge clk);
        applyStimulus(0, 1'b0, 12'h100, 64'h0, 64'h11, 1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("t3_hold_valid", 64'(tcdm_req_q_valid_o), 64'(1));
            checkOutput("t3_hold_addr", 64'(tcdm_req_addr_o), 64'h200);
        end
        @(posedge clk);
        #1;
        tcdm_rsp_q_ready_i = 1'b1;
        waitIdle("t3_idle");

        $display("[TB] ID FIFO full blocks new offers");
        rsp_budget = 0;
        base = grant_cnt;
        applyStimulus(1, 1'b0, 12'h200, 64'h0, 64'h21, 1);
        applyStimulus(2, 1'b0, 12'h300, 64'h0, 64'h31, 1);
        applyStimulus(3, 1'b0, 12'h400, 64'h0, 64'h41, 1);
        applyStimulus(0, 1'b0, 12'h100, 64'h0, 64'h11, 1);
        applyStimulus(0, 1'b0, 12'h108, 64'h0, 64'h12, 1);
        t = 0;
        while (grant_cnt < base + 4 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (grant_cnt < base + 4) reportFail("t4_fill");
        repeat (2) begin
            @(negedge clk);
            checkOutput("t4_full_block", 64'(tcdm_req_q_valid_o), 64'(0));
        end
        rsp_budget = 1;
        @(negedge clk);
        checkOutput("t4_pop_cycle_block", 64'(tcdm_req_q_valid_o), 64'(0));
        @(negedge clk);
        checkOutput("t4_offer_after_pop", 64'(tcdm_req_q_valid_o), 64'(1));
        rsp_budget = -1;
        waitIdle("t4_idle");

        $display("[TB] interleaved reads with varying latency");
        applyStimulus(3, 1'b0, 12'h400, 64'h0, 64'h41, 1);
        applyStimulus(0, 1'b0, 12'h108, 64'h0, 64'h12, 3);
        applyStimulus(3, 1'b0, 12'h408, 64'h0, 64'h42, 2);
        waitIdle("t5_idle");
        checkOutput("t5_no_err", 64'(err_o), 64'(0));

        $display("[TB] response with empty ID FIFO");
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        checkOutput("t6_dropped_rsp", 64'(rsp_p_valid_o), 64'(0));
        inject = 1'b0;
        @(negedge clk);
        checkOutput("t6_err_set", 64'(err_o), 64'(1));
        repeat (5) @(negedge clk);
        checkOutput("t6_err_sticky", 64'(err_o), 64'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("t6_err_async_clear", 64'(err_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t6_err_after_reset", 64'(err_o), 64'(0));

        waitIdle("final_idle");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
